siso_layer_scheduler: RTL and testbench

Sequences one SISO row unit through layered decoding. Each layer is processed as a burst of row-address reads on rdlayer/rdaddress/rden_LLR/rden_E. The scheduler then waits until every row of that layer has been written back (counted on the row unit's wren) before it starts the next layer, which removes the LLR read-after-write hazard across layers. It sits between the decoder top-level control (start/done) and the row unit's registered read-request inputs.

---
 rtl/siso_sched_pkg.sv | 17 +
 rtl/siso_layer_scheduler_if.sv | 22 ++
 rtl/siso_wb_counter.sv | 34 +++
 rtl/siso_layer_scheduler.sv | 146 ++++++++++++++
 tb/tb_siso_layer_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/siso_sched_pkg.sv
// Shared types and default sizing for the SISO layer scheduler and its bench.
package siso_sched_pkg;

  localparam int unsigned LAYERS      = 2;
  localparam int unsigned ADDRDEPTH   = 20;
  localparam int unsigned ADDRWIDTH   = 5;
  localparam int unsigned ITERBITS    = 4;
  localparam int unsigned RD2WREN_LAT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/siso_layer_scheduler_if.sv
// Row-unit side of the scheduler: registered read requests out, writeback strobe back.
interface siso_layer_scheduler_if #(
  parameter int unsigned ADDRWIDTH = siso_sched_pkg::ADDRWIDTH
);

  logic                 rdlayer;
  logic [ADDRWIDTH-1:0] rdaddress;
  logic                 rden_LLR;
  logic                 rden_E;
  logic                 wren;

  modport master (
    output rdlayer, rdaddress, rden_LLR, rden_E,
    input  wren
  );

  modport slave (
    input  rdlayer, rdaddress, rden_LLR, rden_E,
    output wren
  );

endinterface

// File: rtl/siso_wb_counter.sv
// Per-layer writeback counter; saturates at DEPTH and flags any writeback beyond it.
module siso_wb_counter #(
  parameter int unsigned DEPTH = siso_sched_pkg::ADDRDEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic clr,
  output logic terminal,
  output logic overflow
);

  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          step;

  // terminal looks at the count including this cycle's writeback
  always_comb begin
    step     = en & inc;
    overflow = step & (cnt_q == FULL);
    cnt_inc  = (step && !overflow) ? cnt_q + CW'(1) : cnt_q;
    terminal = (cnt_inc == FULL);
    cnt_d    = clr ? '0 : cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/siso_layer_scheduler.sv
// Layered-decoding read scheduler for one SISO row unit; holds each layer until fully written back.
// Optional SCHED_EARLY_TERM_EN: syndrome_ok at an iteration end finishes the decode early.
module siso_layer_scheduler #(
  parameter int unsigned LAYERS    = siso_sched_pkg::LAYERS,
  parameter int unsigned ADDRDEPTH = siso_sched_pkg::ADDRDEPTH,
  parameter int unsigned ADDRWIDTH = siso_sched_pkg::ADDRWIDTH,
  parameter int unsigned ITERBITS  = siso_sched_pkg::ITERBITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITERBITS-1:0]   max_iter,
  input  logic                  syndrome_ok,
  siso_layer_scheduler_if.master row,
  output logic                  busy,
  output logic                  done,
  output logic [ITERBITS-1:0]   iter_count,
  output logic                  err
);

  import siso_sched_pkg::*;

  localparam int unsigned          LW         = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic [LW-1:0]        LAST_LAYER = LW'(LAYERS - 1);

  sched_state_e         state_q, state_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]        layer_q, layer_d;
  logic [ITERBITS-1:0]  iter_q, iter_d, maxit_q, maxit_d, iter_inc;
  logic                 rden_q, rden_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                 wb_en, wb_clr, wb_term, wb_ovf, early_term;

`ifdef SCHED_EARLY_TERM_EN
  assign early_term = syndrome_ok;
`else
  logic unused_syndrome_ok;
  assign unused_syndrome_ok = syndrome_ok;
  assign early_term         = 1'b0;
`endif

  assign wb_en = (state_q == ISSUE) || (state_q == DRAIN);

  siso_wb_counter #(.DEPTH(ADDRDEPTH)) u_wb_counter (
    .clk      (clk),
    .rst      (rst),
    .en       (wb_en),
    .inc      (row.wren),
    .clr      (wb_clr),
    .terminal (wb_term),
    .overflow (wb_ovf)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    layer_d  = layer_q;
    iter_d   = iter_q;
    maxit_d  = maxit_q;
    rden_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wb_clr   = (state_q == IDLE);
    iter_inc = iter_q + ITERBITS'(1);
    err_d    = err_q | wb_ovf | (row.wren && ((state_q == IDLE) || (state_q == FIN)));
    unique case (state_q)
      IDLE: if (start) begin
        maxit_d = max_iter;
        iter_d  = '0;
        layer_d = '0;
        addr_d  = '0;
        if (max_iter != '0) begin
          state_d = ISSUE;
          rden_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      // addr_q is the address on the bus this cycle; advance it or stop after the last row
      ISSUE: if (addr_q == LAST_ADDR) begin
        state_d = DRAIN;
      end else begin
        addr_d = addr_q + ADDRWIDTH'(1);
        rden_d = 1'b1;
      end
      DRAIN: if (wb_term) begin
        wb_clr = 1'b1;
        addr_d = '0;
        if (layer_q != LAST_LAYER) begin
          layer_d = layer_q + LW'(1);
          state_d = ISSUE;
          rden_d  = 1'b1;
        end else begin
          layer_d = '0;
          iter_d  = iter_inc;
          if ((iter_inc == maxit_q) || early_term) begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ISSUE;
            rden_d  = 1'b1;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      layer_q <= '0;
      iter_q  <= '0;
      maxit_q <= '0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      layer_q <= layer_d;
      iter_q  <= iter_d;
      maxit_q <= maxit_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign row.rdlayer   = layer_q[0];
  assign row.rdaddress = addr_q;
  assign row.rden_LLR  = rden_q;
  assign row.rden_E    = rden_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign iter_count    = iter_q;
  assign err           = err_q;

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Scoreboard bench for siso_layer_scheduler with a latency-configurable row-unit model.
module tb_siso_layer_scheduler;

  import siso_sched_pkg::*;

  localparam int SCHED_N = 20000;

  typedef struct {
    bit is_done;
    int layer;
    int addr;
    int iter;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ITERBITS-1:0] max_iter = '0;
  logic                syndrome_ok = 1'b0;
  logic                busy, done, err;
  logic [ITERBITS-1:0] iter_count;

  siso_layer_scheduler_if #(.ADDRWIDTH(ADDRWIDTH)) row_if ();

  siso_layer_scheduler #(
    .LAYERS    (LAYERS),
    .ADDRDEPTH (ADDRDEPTH),
    .ADDRWIDTH (ADDRWIDTH),
    .ITERBITS  (ITERBITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .max_iter    (max_iter),
    .syndrome_ok (syndrome_ok),
    .row         (row_if),
    .busy        (busy),
    .done        (done),
    .iter_count  (iter_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Row-unit model: each read returns a writeback lat cycles later, one per cycle at most.
  bit                   sched [SCHED_N];
  int                   lat = RD2WREN_LAT;
  bit                   delay_en = 1'b0;
  logic [ADDRWIDTH-1:0] delay_row = '0;
  logic                 delay_layer = 1'b0;
  int                   delay_extra = 0;
  int                   reads_seen = 0;
  int                   synd_after = 0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = cyc; i < SCHED_N; i++) sched[i] = 1'b0;
    end else if (row_if.rden_LLR) begin
      int t;
      t = cyc + lat;
      if (delay_en && row_if.rdaddress == delay_row && row_if.rdlayer == delay_layer) t += delay_extra;
      while (t < SCHED_N - 1 && sched[t]) t++;
      sched[t] = 1'b1;
      reads_seen++;
    end
  end

  initial row_if.wren = 1'b0;
  always @(posedge clk) begin
    #1;
    row_if.wren = (cyc < SCHED_N) ? sched[cyc] : 1'b0;
    syndrome_ok = (synd_after != 0) && (reads_seen >= synd_after);
  end

  // Reference model and monitor
  exp_t q[$];
  exp_t it;
  bit   armed = 1'b0, rst_prev = 1'b0, run = 1'b0, pending = 1'b0, err_exp = 1'b0, fin_c;
  int   next_evt = 0, win = 0, nreads = 0, last_rd = 0;

  always @(negedge clk) begin
    fin_c = pending && (next_evt == cyc) && (q.size() > 0) && q[0].is_done;
    if (armed && rst_prev) begin
      check("rst_outputs", {row_if.rden_LLR, row_if.rden_E, row_if.rdlayer, row_if.rdaddress,
                            busy, done, iter_count, err}, '0);
    end else if (armed) begin
      check("err", err, err_exp);
      check("busy", busy, run);
      check("rden_pair", row_if.rden_E, row_if.rden_LLR);
      if (row_if.rden_LLR) begin
        if (q.size() == 0 || q[0].is_done) fail_now("unexpected_read");
        else begin
          it = q.pop_front();
          check("rdlayer", row_if.rdlayer, it.layer[0]);
          check("rdaddress", row_if.rdaddress, it.addr);
          if (it.addr == 0) begin
            check("layer_start_cycle", cyc, next_evt);
            pending = 1'b0;
          end else check("burst_gap", cyc, last_rd + 1);
          last_rd = cyc;
          nreads++;
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) fail_now("unexpected_done");
        else begin
          it = q.pop_front();
          check("iter_count", iter_count, it.iter);
          check("done_cycle", cyc, next_evt);
          pending = 1'b0;
        end
      end
      if (pending && cyc >= next_evt) begin
        fail_now("event_missing");
        pending = 1'b0;
      end
    end

    if (rst) begin
      armed = 1'b1; q.delete(); run = 1'b0; pending = 1'b0; err_exp = 1'b0; win = 0; nreads = 0;
    end else begin
      if (row_if.wren) begin
        if (!run || win == int'(ADDRDEPTH)) err_exp = 1'b1;
        else win++;
      end
      if (run && nreads == int'(ADDRDEPTH) && cyc > last_rd && win == int'(ADDRDEPTH)) begin
        win = 0; nreads = 0; pending = 1'b1; next_evt = cyc + 1;
        if (q.size() == 0 || q[0].is_done) run = 1'b0;
      end else if (!run && start && !fin_c) begin
        pending = 1'b1; next_evt = cyc + 1; win = 0; nreads = 0;
        if (max_iter != '0) run = 1'b1;
      end
    end
    rst_prev = rst;
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_decode(input int n_iter);
    exp_t e;
    for (int i = 0; i < n_iter; i++)
      for (int l = 0; l < int'(LAYERS); l++)
        for (int a = 0; a < int'(ADDRDEPTH); a++) begin
          e.is_done = 1'b0; e.layer = l; e.addr = a; e.iter = 0;
          q.push_back(e);
        end
    e.is_done = 1'b1; e.layer = 0; e.addr = 0; e.iter = n_iter;
    q.push_back(e);
  endtask

  task automatic start_decode(input int mi, input int n_iter);
    push_decode(n_iter);
    reads_seen = 0;
    tick();
    start = 1'b1;
    max_iter = ITERBITS'(mi);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= budget) fail_now("done_timeout");
    tick();
    tick();
  endtask

  task automatic row_defaults();
    lat = RD2WREN_LAT; delay_en = 1'b0; delay_extra = 0; synd_after = 0;
  endtask

  initial begin
    int mi, n_exp;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // nominal: two iterations, 10-cycle row latency
    start_decode(2, 2);
    wait_done(2000);

    // zero iterations: immediate done, no reads
    start_decode(0, 0);
    wait_done(20);

    // one late writeback holds the next layer
    delay_en = 1'b1; delay_row = ADDRWIDTH'(5); delay_layer = 1'b0; delay_extra = 15;
    start_decode(1, 1);
    wait_done(2000);
    row_defaults();

    // early termination request at the end of iteration 2
    synd_after = 2 * int'(LAYERS) * int'(ADDRDEPTH);
`ifdef SCHED_EARLY_TERM_EN
    n_exp = 2;
`else
    n_exp = 5;
`endif
    start_decode(5, n_exp);
    wait_done(3000);
    row_defaults();

    // random latencies, late rows and ignored start while busy
    for (int k = 0; k < 6; k++) begin
      mi = int'($urandom_range(1, 3));
      lat = int'($urandom_range(1, 12));
      delay_en = 1'b1;
      delay_row = ADDRWIDTH'($urandom_range(0, ADDRDEPTH - 1));
      delay_layer = 1'($urandom_range(0, 1));
      delay_extra = int'($urandom_range(0, 20));
      start_decode(mi, mi);
      repeat (30) tick();
      start = 1'b1;
      max_iter = ITERBITS'($urandom_range(0, 15));
      tick();
      start = 1'b0;
      wait_done(2000);
    end
    row_defaults();

    // 21 writebacks inside one layer
    lat = 1;
    push_decode(1);
    reads_seen = 0;
    tick();
    sched[cyc + 1] = 1'b1;
    start = 1'b1;
    max_iter = ITERBITS'(1);
    tick();
    start = 1'b0;
    wait_done(500);
    row_defaults();

    // reset clears err; then a stray writeback in IDLE sets it again
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    sched[cyc + 2] = 1'b1;
    repeat (5) tick();
    start_decode(1, 1);
    wait_done(2000);

    // reset in the middle of a burst, then a fresh decode
    start_decode(2, 2);
    repeat (8) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    start_decode(1, 1);
    wait_done(2000);

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
